// File: rtl/fp_add_normalizer.sv
// Post-add normalizer: shifts the adder sum into normal form, fixes up the exponent, flags zero/overflow/underflow and packs IEEE-754.
// Define FP_NORM_FTZ_EN to flush denormal results to signed zero instead of emitting them.
module fp_add_normalizer #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_carry,
  input  logic [MANT_W:0]           in_mant,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic                      in_sign,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W:0]     out_result,
  output logic                      out_zero,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
  localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);
  localparam logic [MANT_W-1:0] FRAC_ZERO = '0;

  state_t                  state_q;
  logic                    carry_q;
  logic                    sign_q;
  logic                    first_q;
  logic [MANT_W:0]         mant_q;
  logic [EXP_W-1:0]        exp_q;
  logic                    out_valid_q;
  logic [EXP_W+MANT_W:0]   out_result_q;
  logic                    zero_q;
  logic                    overflow_q;
  logic                    underflow_q;

  logic [EXP_W-1:0]        exp_inc;
  logic [MANT_W:0]         mant_rsh;
  logic [MANT_W:0]         mant_lsh;

  assign exp_inc  = exp_q + EXP_ONE;
  assign mant_rsh = {carry_q, mant_q[MANT_W:1]};
  assign mant_lsh = {mant_q[MANT_W-1:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      carry_q      <= 1'b0;
      sign_q       <= 1'b0;
      first_q      <= 1'b0;
      mant_q       <= '0;
      exp_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            carry_q     <= in_carry;
            mant_q      <= in_mant;
            exp_q       <= in_exp;
            sign_q      <= in_sign;
            first_q     <= 1'b1;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            state_q     <= NORM;
          end
        end
        NORM: begin
          first_q <= 1'b0;
          if (carry_q) begin
            carry_q <= 1'b0;
            mant_q  <= mant_rsh;
            exp_q   <= exp_inc;
            if (exp_inc == EXP_MAX) begin
              out_result_q <= {sign_q, EXP_MAX, FRAC_ZERO};
              overflow_q   <= 1'b1;
            end else begin
              out_result_q <= {sign_q, exp_inc, mant_rsh[MANT_W-1:0]};
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (first_q && (exp_q == EXP_MAX)) begin
            out_result_q <= {sign_q, EXP_MAX, FRAC_ZERO};
            overflow_q   <= 1'b1;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else if (mant_q == '0) begin
            out_result_q <= '0;
            zero_q       <= 1'b1;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else if (mant_q[MANT_W]) begin
            out_result_q <= {sign_q, exp_q, mant_q[MANT_W-1:0]};
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else if (exp_q > EXP_ONE) begin
            mant_q <= mant_lsh;
            exp_q  <= exp_q - EXP_ONE;
          end else begin
            // Exponent exhausted before the hidden bit surfaced.
`ifdef FP_NORM_FTZ_EN
            out_result_q <= {sign_q, {EXP_W{1'b0}}, FRAC_ZERO};
            zero_q       <= 1'b1;
`else
            out_result_q <= {sign_q, {EXP_W{1'b0}}, mant_q[MANT_W-1:0]};
`endif
            underflow_q  <= 1'b1;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_zero      = zero_q;
  assign out_overflow  = overflow_q;
  assign out_underflow = underflow_q;

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed bench for fp_add_normalizer: latency, packing, flags, backpressure and mid-operation reset.
module tb_fp_add_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_carry;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_normalizer #(.MANT_W(23), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_carry(in_carry),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, measure cycles from accept to out_valid and check the result.
  task automatic run_op(input string tag, input logic c, input logic [23:0] m, input logic [7:0] e,
                        input logic s, input logic [31:0] exp_res, input logic [2:0] exp_flags,
                        input int exp_lat);
    int n;
    in_carry = c; in_mant = m; in_exp = e; in_sign = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_flags"}, {29'd0, out_zero, out_overflow, out_underflow}, {29'd0, exp_flags});
    tick();
    chk({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; in_carry = 1'b0; in_mant = '0; in_exp = '0; in_sign = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", {out_valid, in_ready, busy, out_zero, out_overflow, out_underflow}, 32'b010000);
    chk("rst_result", out_result, 32'h0);

    // flags encoded {zero, overflow, underflow}
    run_op("carry",   1'b1, 24'h800000, 8'd127, 1'b0, 32'h40400000, 3'b000, 2);
    run_op("shift2",  1'b0, 24'h200000, 8'd130, 1'b1, 32'hC0000000, 3'b000, 4);
    run_op("zero",    1'b0, 24'h000000, 8'd90,  1'b1, 32'h00000000, 3'b100, 2);
    run_op("ovf",     1'b1, 24'h800000, 8'd254, 1'b0, 32'h7F800000, 3'b010, 2);
    run_op("inf_in",  1'b0, 24'h800000, 8'd255, 1'b1, 32'hFF800000, 3'b010, 2);
    run_op("normal",  1'b0, 24'hABCDEF, 8'd10,  1'b0, 32'h052BCDEF, 3'b000, 2);
    run_op("maxshft", 1'b0, 24'h000001, 8'd100, 1'b0, 32'h26800000, 3'b000, 25);
`ifdef FP_NORM_FTZ_EN
    run_op("denorm",  1'b0, 24'h000001, 8'd3,   1'b0, 32'h00000000, 3'b101, 4);
    run_op("denorm1", 1'b0, 24'h400000, 8'd1,   1'b1, 32'h80000000, 3'b101, 2);
`else
    run_op("denorm",  1'b0, 24'h000001, 8'd3,   1'b0, 32'h00000004, 3'b001, 4);
    run_op("denorm1", 1'b0, 24'h400000, 8'd1,   1'b1, 32'h80400000, 3'b001, 2);
`endif

    // Backpressure: result held in DONE, new input ignored.
    out_ready = 1'b0;
    in_carry = 1'b1; in_mant = 24'h800000; in_exp = 8'd127; in_sign = 1'b1; in_valid = 1'b1;
    tick();
    in_carry = 1'b0; in_mant = 24'h000000; in_exp = 8'd5; in_sign = 1'b0;
    tick();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    held = out_result;
    chk("bp_res0", held, 32'hC0400000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", out_result, 32'hC0400000);
      chk("bp_hold", {29'd0, out_valid, in_ready, busy}, 32'b101);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
    tick();
    chk("bp_no_ghost", {29'd0, out_valid, in_ready, busy}, 32'b010);

    // Reset during a long normalization discards the operation.
    in_carry = 1'b0; in_mant = 24'h000001; in_exp = 8'd100; in_sign = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", {29'd0, out_valid, in_ready, busy}, 32'b010);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      chk("mid_discard", {31'd0, seen}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
